counter_nbit: RTL and testbench
===============================

COUNTER_NBIT -- requirements
Module: counter_nbit

Interface
REQ-001 Parameter N, default 8, counter width in bits (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 count_en  input  1  count enable; 1 = advance one step per cycle.
REQ-005 count_clr  input  1  synchronous clear of count and overflow.
REQ-006 count_dir  input  1  direction; 1 = up, 0 = down.
REQ-007 count  output  N  current count value, registered.
REQ-008 overflow  output  1  wrap indicator, registered, one-cycle pulse.

Function
REQ-009 The block SHALL evaluate one action per rising clk edge, in priority order: rst, count_clr, load (only when COUNTER_LOAD_EN is defined), count_en, hold.
REQ-010 The block SHALL set count = 0 and overflow = 0 on count_clr = 1, regardless of count_en and count_dir.
REQ-011 Up count (count_en = 1, count_dir = 1) SHALL set count = count + 1 modulo 2^N.
REQ-012 Down count (count_en = 1, count_dir = 0) SHALL set count = count - 1 modulo 2^N.
REQ-013 Up wrap, 2^N-1 -> 0, SHALL set overflow = 1 in the same edge as the wrap.
REQ-014 Down wrap, 0 -> 2^N-1, SHALL set overflow = 1 in the same edge as the wrap.
REQ-015 Overflow SHALL be 0 after every other edge, including non-wrapping steps, hold cycles (count_en = 0) and clear.
REQ-016 Overflow SHALL stay high for exactly one cycle per wrap.
REQ-017 count_en = 0 SHALL hold count unchanged.
REQ-018 count_dir SHALL be sampled every cycle, so a direction change takes effect on the next enabled edge with no penalty cycle.
REQ-019 Both outputs SHALL come directly from flops, with no combinational path from inputs to outputs.
REQ-020 The block SHALL have one cycle of latency from input change to visible output change.

Reset
REQ-021 rst = 1 at a rising edge SHALL force count = 0 and overflow = 0, overriding all other inputs.
REQ-022 Reset SHALL take effect mid-count, and the count SHALL resume from 0 on the first edge after rst deasserts.
REQ-023 Outputs SHALL be undefined until the first edge with rst = 1; the bench holds rst for at least one edge.

Configuration
REQ-024 Macro COUNTER_LOAD_EN SHALL control the parallel-load feature.
REQ-025 When COUNTER_LOAD_EN is defined, the block SHALL add input count_load (1 bit) and input load_val (N bits).
REQ-026 When COUNTER_LOAD_EN is defined and count_load = 1 with count_clr = 0, the block SHALL set count = load_val and overflow = 0, regardless of count_en.
REQ-027 When COUNTER_LOAD_EN is not defined, the count_load and load_val ports SHALL be absent and behaviour SHALL follow REQ-009 to REQ-023 only.

Verification
REQ-028 rst = 1 for 2 edges, then rst = 0 with count_en = 0 -> count = 0 and overflow = 0 every cycle.
REQ-029 N = 8, count_en = 1, count_dir = 1, run 258 cycles from 0 -> count steps 1..255, then 0 with overflow = 1 for one cycle only, then 1, 2 with overflow = 0.
REQ-030 count_clr = 1 for one edge at count = 2 -> count = 0 and overflow = 0; then count_dir = 0 for 258 cycles -> 255 with overflow = 1, then 254..0, then 255 with overflow = 1 again, then 254.
REQ-031 count_en = 0 at count = 254 -> count stays 254 and overflow = 0 for 3 cycles.
REQ-032 rst = 1 at count = 100 with count_en = 1 and count_clr = 1 -> count = 0 and overflow = 0 next edge; rst deasserted -> counts 1, 2.
REQ-033 With COUNTER_LOAD_EN defined: load_val = 255, count_load = 1 with count_dir = 1 -> count = 255 and overflow = 0; next up edge -> count = 0 and overflow = 1; count_load together with count_clr -> count = 0.

Source files
------------

// File: rtl/counter_nbit_if.sv
// Handshake bundle for counter_nbit: control inputs in, registered count/overflow out.
// The load signals exist only when COUNTER_LOAD_EN is defined.
interface counter_nbit_if #(
  parameter int N = 8
);
  logic         count_en;
  logic         count_clr;
  logic         count_dir;
`ifdef COUNTER_LOAD_EN
  logic         count_load;
  logic [N-1:0] load_val;
`endif
  logic [N-1:0] count;
  logic         overflow;

  modport master (
`ifdef COUNTER_LOAD_EN
    output count_load,
    output load_val,
`endif
    output count_en,
    output count_clr,
    output count_dir,
    input  count,
    input  overflow
  );

  modport slave (
`ifdef COUNTER_LOAD_EN
    input  count_load,
    input  load_val,
`endif
    input  count_en,
    input  count_clr,
    input  count_dir,
    output count,
    output overflow
  );
endinterface

// File: rtl/counter_nbit.sv
// N-bit up/down wrapping counter with a one-cycle overflow pulse on each wrap.
// Optional parallel load is enabled by defining COUNTER_LOAD_EN.
module counter_nbit #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  counter_nbit_if.slave  bus
);

  logic [N-1:0] count_r;
  logic         overflow_r;
  logic [N-1:0] count_next_s;
  logic         overflow_next_s;

  // Next-state selection in priority order: clear, load, step, hold.
  always_comb begin
    count_next_s    = count_r;
    overflow_next_s = 1'b0;
    if (bus.count_clr) begin
      count_next_s    = {N{1'b0}};
      overflow_next_s = 1'b0;
    end
`ifdef COUNTER_LOAD_EN
    else if (bus.count_load) begin
      count_next_s    = bus.load_val;
      overflow_next_s = 1'b0;
    end
`endif
    else if (bus.count_en) begin
      if (bus.count_dir) begin
        count_next_s    = count_r + {{(N-1){1'b0}}, 1'b1};
        overflow_next_s = (count_r == {N{1'b1}});
      end else begin
        count_next_s    = count_r - {{(N-1){1'b0}}, 1'b1};
        overflow_next_s = (count_r == {N{1'b0}});
      end
    end else begin
      count_next_s    = count_r;
      overflow_next_s = 1'b0;
    end
  end

  // State and output flops; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= {N{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      count_r    <= count_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_counter_nbit.sv
// Scoreboard bench for counter_nbit: directed wrap/clear/hold/reset sequences plus random stimulus.
module tb_counter_nbit;
  localparam int N   = 8;
  localparam int MOD = 1 << N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_nbit_if #(.N(N)) bus ();
  counter_nbit #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [N:0] sb_q[$];
  int checks = 0;
  int fails  = 0;
  int model_count = 0;
  int cyc = 0;

  // Behavioural reference: integer arithmetic modulo 2^N.
  task automatic step(input bit r, input bit clr, input bit en, input bit dir,
                      input bit ld, input int lv);
    bit wrap;
    @(negedge clk);
    rst = r;
    bus.count_clr = clr;
    bus.count_en  = en;
    bus.count_dir = dir;
`ifdef COUNTER_LOAD_EN
    bus.count_load = ld;
    bus.load_val   = lv[N-1:0];
`endif
    wrap = 1'b0;
    if (r || clr) begin
      model_count = 0;
    end
`ifdef COUNTER_LOAD_EN
    else if (ld) begin
      model_count = lv % MOD;
    end
`endif
    else if (en) begin
      if (dir) begin
        wrap = (model_count == MOD - 1);
        model_count = (model_count + 1) % MOD;
      end else begin
        wrap = (model_count == 0);
        model_count = (model_count + MOD - 1) % MOD;
      end
    end
    sb_q.push_back({wrap, model_count[N-1:0]});
  endtask

  task automatic run(input int n, input bit en, input bit dir);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, en, dir, 1'b0, 0);
  endtask

  // Monitor: one registered output per edge, compared against the queue head.
  initial begin
    logic [N:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        cyc++;
        checks++;
        if (bus.count !== exp[N-1:0]) begin
          fails++;
          $display("FAIL count cyc=%0d actual=%0d required=%0d", cyc, bus.count, exp[N-1:0]);
        end
        checks++;
        if (bus.overflow !== exp[N]) begin
          fails++;
          $display("FAIL overflow cyc=%0d actual=%0b required=%0b", cyc, bus.overflow, exp[N]);
        end
      end
    end
  end

  initial begin
    int lv;
    rst = 1'b1;
    bus.count_clr = 1'b0;
    bus.count_en  = 1'b0;
    bus.count_dir = 1'b1;
`ifdef COUNTER_LOAD_EN
    bus.count_load = 1'b0;
    bus.load_val   = {N{1'b0}};
`endif
    // Reset for two edges, then idle.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run(3, 1'b0, 1'b1);
    // Up through a full wrap, clear at 2, then down through two wraps.
    run(258, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run(258, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    // Climb to 100, reset mid-count with clear and enable active, then resume.
    run(102, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run(2, 1'b1, 1'b1);
    // Direction flip with no penalty cycle.
    run(3, 1'b1, 1'b0);
    run(3, 1'b1, 1'b1);
`ifdef COUNTER_LOAD_EN
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 255);
    run(1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 77);
`endif
    // Randomised phase.
    for (int i = 0; i < 600; i++) begin
      lv = $urandom_range(MOD - 1, 0);
      step($urandom_range(49, 0) == 0, $urandom_range(19, 0) == 0,
           $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
           $urandom_range(9, 0) == 0, lv);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
